truth_table_sweep: RTL and testbench
====================================

# truth_table_sweep

Synthesizable, parametrised truth-table engine for small combinational blocks. It drives every input combination of an N_IN-input, N_OUT-output function in ascending binary order and waits a programmable settle time per vector. It captures the function's response into a packed table and compares it against an expected table. It sits beside a combinational block under test as an on-chip self-checker, replacing the exhaustive simulation-only sweep of the 3-input case.

## Interface
- N_IN, 3, number of function inputs (1..8); vector bit N_IN-1 is the MSB, equivalent to X in the 3-input case
- N_OUT, 1, number of function outputs (1..8)
- SETTLE, 2, cycles each vector is held before its response is sampled (>=1)
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a sweep; accepted only when idle
- expected  input  2^N_IN*N_OUT  reference table; slice [i*N_OUT +: N_OUT] is the response to vector i
- f_in  input  N_OUT  response of the block under test
- vec  output  N_IN  vector driven to the block under test
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse, sweep complete
- table_out  output  2^N_IN*N_OUT  captured responses, same packing as expected
- err_count  output  N_IN+1  number of vectors whose response mismatched
- first_err  output  N_IN  lowest mismatching vector index; 0 if err_count==0
- pass  output  1  high with done and held afterwards when err_count==0

## Operation
- States: IDLE, RUN. There is no separate done state; done is a registered pulse.
- IDLE, start=1 at an edge:
  - Next state is RUN.
  - busy=1, vec=0, settle counter=0.
  - table_out, err_count, first_err and pass clear to 0.
- RUN, each edge:
  - While settle counter < SETTLE-1, the counter increments.
  - Otherwise it is a sample edge for index i=vec:
    - table_out slice i <= f_in.
    - If f_in != expected slice i, err_count increments, and first_err <= i when err_count was 0.
    - Counter resets to 0.
- RUN, sample edge with vec < 2^N_IN-1: vec increments.
- RUN, sample edge with vec == 2^N_IN-1:
  - Next state is IDLE; busy=0, vec=0.
  - done=1 for one cycle.
  - pass <= 1 when the final err_count is 0; the final err_count includes this last comparison.
- start is ignored in RUN.
- Results are held from done until the next accepted start.
- expected is sampled live at each sample edge and must be stable during RUN.
- err_count cannot overflow, because its width covers 2^N_IN.

## Timing
- Reset value of every output: vec=0, busy=0, done=0, table_out=0, err_count=0, first_err=0, pass=0. State=IDLE, counter=0.
- Each vector is held for exactly SETTLE cycles, and f_in is sampled at the last edge of that window.
- With the start-accept edge as E0, sample edges fall at E(k*SETTLE) for k=1..2^N_IN.
- done is high during the cycle following edge E(2^N_IN*SETTLE).
- Start-to-done latency is 2^N_IN*SETTLE cycles.
- start high during the done cycle is accepted at the edge ending that cycle, giving back-to-back sweeps with zero dead cycles beyond done.
- rst mid-sweep:
  - All state returns to reset values on that edge and partial results are discarded.
  - A start asserted together with rst is ignored.

## Structure
- Shared package sweep_pkg holds:
  - the state encoding constants (IDLE, RUN)
  - a function giving table width 2^n*m
  - a function giving the settle-counter width clog2(SETTLE), minimum 1
- Natural sub-module: sweep_settle_cnt, a parametrised modulo-SETTLE counter with a wrap pulse.
- The top level holds the FSM, vector register, capture and compare logic.

## Test plan
- Default parameters, f_in=(X&Y)|Z modelled from vec, expected=8'hEA:
  - table_out=8'hEA, err_count=0, first_err=0, pass=1.
  - done rises 16 cycles after the start edge.
- Same setup with the model inverting the response for vec 3 and vec 5:
  - table_out=8'hC2, err_count=2, first_err=3, pass=0.
- SETTLE=1 and SETTLE=4, N_IN=3:
  - busy high for 8 and 32 cycles respectively.
  - Each vec value is held exactly SETTLE cycles.
  - A response changed one cycle before the sample edge is captured; one changed after it is not.
- rst asserted while vec=4:
  - All outputs are 0 on the next cycle.
  - start asserted together with rst is ignored.
  - A subsequent start produces a correct full sweep.
- start held high continuously:
  - The second sweep begins the edge after the done pulse.
  - start pulses during RUN do not restart or disturb the sweep.
- N_IN=4, N_OUT=2, model f={^vec, vec[3]} with a matching expected table:
  - pass=1, err_count=0, and table_out equals expected bit for bit.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweep engine: FSM state encoding and
// the width helpers used to size the response tables and the settle counter.
package sweep_pkg;

  // Two-state sweep controller; completion is signalled by a registered pulse
  // rather than a dedicated state.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width of a packed response table: one N_OUT-wide slice per input vector.
  function automatic int table_w(input int n_in, input int n_out);
    return (1 << n_in) * n_out;
  endfunction

  // Width of the settle counter: clog2(SETTLE), never narrower than one bit
  // so that SETTLE=1 still yields a legal register.
  function automatic int settle_cnt_w(input int settle);
    int w;
    w = $clog2(settle);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sweep_settle_cnt.sv
// Modulo-SETTLE counter. While enabled it counts 0..SETTLE-1 and raises a
// combinational wrap pulse during the last count, which marks the edge at
// which the current vector has been held for SETTLE cycles.
module sweep_settle_cnt
  import sweep_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CNT_W  = settle_cnt_w(SETTLE)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_wrap
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  assign o_wrap = i_en && (r_cnt == LAST);

  // Count while enabled, restart on wrap or when a new sweep is accepted.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (o_wrap) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/truth_table_sweep.sv
// On-chip exhaustive truth-table checker. Drives every input vector of an
// N_IN-input / N_OUT-output combinational block in ascending order, holds each
// for SETTLE cycles, captures the response at the end of the window and
// compares it against a reference table, reporting a mismatch count, the
// lowest failing vector and an overall pass flag.
module truth_table_sweep
  import sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [table_w(N_IN, N_OUT)-1:0]  expected,
  input  logic [N_OUT-1:0]                 f_in,
  output logic [N_IN-1:0]                  vec,
  output logic                             busy,
  output logic                             done,
  output logic [table_w(N_IN, N_OUT)-1:0]  table_out,
  output logic [N_IN:0]                    err_count,
  output logic [N_IN-1:0]                  first_err,
  output logic                             pass
);

  localparam int                TBL_W    = table_w(N_IN, N_OUT);
  localparam logic [N_IN-1:0]   LAST_VEC = '1;
  localparam logic [N_IN-1:0]   VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]     ERR_ONE  = (N_IN + 1)'(1);

  state_t              r_state;
  logic [N_IN-1:0]     r_vec;
  logic                r_busy;
  logic                r_done;
  logic [TBL_W-1:0]    r_table;
  logic [N_IN:0]       r_err_count;
  logic [N_IN-1:0]     r_first_err;
  logic                r_pass;

  logic                w_accept;
  logic                w_running;
  logic                w_sample;
  logic                w_last;
  logic                w_mismatch;
  int                  w_base;
  logic [N_OUT-1:0]    w_exp_slice;

  // A start is only honoured from IDLE; in RUN it is ignored entirely.
  assign w_accept  = (r_state == IDLE) && start;
  assign w_running = (r_state == RUN);

  // Table slice addressed by the vector currently under test. The reference
  // is read live at the sample edge, so it must not move during a sweep.
  assign w_base      = int'(r_vec) * N_OUT;
  assign w_exp_slice = expected[w_base +: N_OUT];
  assign w_mismatch  = (f_in != w_exp_slice);
  assign w_last      = (r_vec == LAST_VEC);

  sweep_settle_cnt #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_en   (w_running),
    .o_wrap (w_sample)
  );

  // Sweep controller: accept start, capture/compare on each settle wrap,
  // advance the vector, and pulse done after the final vector's comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_vec       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_table     <= '0;
      r_err_count <= '0;
      r_first_err <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_vec       <= '0;
            r_table     <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_pass      <= 1'b0;
          end
        end
        RUN: begin
          if (w_sample) begin
            r_table[w_base +: N_OUT] <= f_in;
            if (w_mismatch) begin
              r_err_count <= r_err_count + ERR_ONE;
              if (r_err_count == '0) begin
                r_first_err <= r_vec;
              end
            end
            if (w_last) begin
              // Final verdict must include the comparison made on this edge.
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_vec   <= '0;
              r_done  <= 1'b1;
              r_pass  <= (r_err_count == '0) && !w_mismatch;
            end else begin
              r_vec <= r_vec + VEC_ONE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign vec       = r_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign table_out = r_table;
  assign err_count = r_err_count;
  assign first_err = r_first_err;
  assign pass      = r_pass;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Scoreboard bench for truth_table_sweep. Four instances cover the default
// configuration, SETTLE=1, SETTLE=4 with timed response changes, and a
// 4-input/2-output function. Expected sweep results are queued when a sweep
// is launched; a negedge monitor pops and compares on every done pulse.
module tb_truth_table_sweep;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] t_start;
  logic [3:0] t_rst;

  // Instance A: defaults (N_IN=3, N_OUT=1, SETTLE=2)
  logic [7:0] a_flip;
  logic       a_f;
  logic [2:0] a_vec, a_first;
  logic [3:0] a_err;
  logic [7:0] a_tbl;
  logic       a_busy, a_done, a_pass;

  // Instance B: SETTLE=1
  logic       b_f;
  logic [2:0] b_vec, b_first;
  logic [3:0] b_err;
  logic [7:0] b_tbl;
  logic       b_busy, b_done, b_pass;

  // Instance C: SETTLE=4
  logic       c_f, c_glitch;
  logic [2:0] c_vec, c_first;
  logic [3:0] c_err;
  logic [7:0] c_tbl;
  logic       c_busy, c_done, c_pass;

  // Instance D: N_IN=4, N_OUT=2
  logic [1:0]  d_f;
  logic [3:0]  d_vec, d_first;
  logic [4:0]  d_err;
  logic [31:0] d_tbl;
  logic        d_busy, d_done, d_pass;

  // Per-instance hold-time tracking (updated at each negedge)
  int age  [4];
  int hmin [4];
  int hmax [4];
  int bcnt [4];
  logic [7:0] prev_vec  [4];
  logic       prev_busy [4];

  function automatic logic f3(input logic [2:0] v);
    return (v[2] & v[1]) | v[0];
  endfunction

  assign a_f = f3(a_vec) ^ a_flip[a_vec];
  assign b_f = f3(b_vec);
  // vec 2: response flips only in the last cycle before its sample edge (captured)
  // vec 5: response wrong for the first three cycles, correct at the sample edge
  assign c_glitch = ((c_vec == 3'd2) && (age[2] == 3)) ||
                    ((c_vec == 3'd5) && (age[2] < 3));
  assign c_f = f3(c_vec) ^ c_glitch;
  assign d_f = {^d_vec, d_vec[3]};

  truth_table_sweep u_a (
    .clk(clk), .rst(t_rst[0]), .start(t_start[0]), .expected(8'hEA), .f_in(a_f),
    .vec(a_vec), .busy(a_busy), .done(a_done), .table_out(a_tbl),
    .err_count(a_err), .first_err(a_first), .pass(a_pass));

  truth_table_sweep #(.N_IN(3), .N_OUT(1), .SETTLE(1)) u_b (
    .clk(clk), .rst(t_rst[1]), .start(t_start[1]), .expected(8'hEA), .f_in(b_f),
    .vec(b_vec), .busy(b_busy), .done(b_done), .table_out(b_tbl),
    .err_count(b_err), .first_err(b_first), .pass(b_pass));

  truth_table_sweep #(.N_IN(3), .N_OUT(1), .SETTLE(4)) u_c (
    .clk(clk), .rst(t_rst[2]), .start(t_start[2]), .expected(8'hEA), .f_in(c_f),
    .vec(c_vec), .busy(c_busy), .done(c_done), .table_out(c_tbl),
    .err_count(c_err), .first_err(c_first), .pass(c_pass));

  truth_table_sweep #(.N_IN(4), .N_OUT(2), .SETTLE(2)) u_d (
    .clk(clk), .rst(t_rst[3]), .start(t_start[3]), .expected(32'h7DD78228), .f_in(d_f),
    .vec(d_vec), .busy(d_busy), .done(d_done), .table_out(d_tbl),
    .err_count(d_err), .first_err(d_first), .pass(d_pass));

  // Uniform views of the four instances
  logic [3:0]        m_done, m_busy, m_pass;
  logic [3:0][31:0]  m_tbl;
  logic [3:0][7:0]   m_vec, m_err, m_first;

  assign m_done  = {d_done, c_done, b_done, a_done};
  assign m_busy  = {d_busy, c_busy, b_busy, a_busy};
  assign m_pass  = {d_pass, c_pass, b_pass, a_pass};
  assign m_tbl   = {d_tbl, {24'h0, c_tbl}, {24'h0, b_tbl}, {24'h0, a_tbl}};
  assign m_vec   = {{4'h0, d_vec}, {5'h0, c_vec}, {5'h0, b_vec}, {5'h0, a_vec}};
  assign m_err   = {{3'h0, d_err}, {4'h0, c_err}, {4'h0, b_err}, {4'h0, a_err}};
  assign m_first = {{4'h0, d_first}, {5'h0, c_first}, {5'h0, b_first}, {5'h0, a_first}};

  typedef struct {
    int     ch;
    longint tbl;
    int     err;
    int     first;
    int     pass;
    int     busy;
    int     hold;
  } rec_t;

  rec_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_sweep(input int ch, input longint tbl, input int err,
                              input int first, input int pass, input int busy,
                              input int hold);
    rec_t r;
    r.ch = ch; r.tbl = tbl; r.err = err; r.first = first;
    r.pass = pass; r.busy = busy; r.hold = hold;
    sb_q.push_back(r);
  endtask

  task automatic wait_done(input int ch);
    int n;
    n = 0;
    while (!m_done[ch] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!m_done[ch]) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout ch=%0d: got no done, expected done within 500 cycles", ch);
    end
  endtask

  task automatic run_sweep(input int ch);
    t_start[ch] = 1'b1;
    @(negedge clk);
    t_start[ch] = 1'b0;
    wait_done(ch);
    @(negedge clk);
  endtask

  // Hold-time tracker and scoreboard monitor
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (m_busy[c] && !prev_busy[c]) begin
        age[c]  = 0;
        hmin[c] = 1000;
        hmax[c] = 0;
        bcnt[c] = 1;
      end else if (m_busy[c]) begin
        bcnt[c]++;
        if (m_vec[c] != prev_vec[c]) begin
          if (age[c] + 1 < hmin[c]) hmin[c] = age[c] + 1;
          if (age[c] + 1 > hmax[c]) hmax[c] = age[c] + 1;
          age[c] = 0;
        end else begin
          age[c]++;
        end
      end else if (prev_busy[c]) begin
        if (age[c] + 1 < hmin[c]) hmin[c] = age[c] + 1;
        if (age[c] + 1 > hmax[c]) hmax[c] = age[c] + 1;
      end
      prev_busy[c] = m_busy[c];
      prev_vec[c]  = m_vec[c];

      if (m_done[c]) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done ch=%0d: got done, expected no sweep completion", c);
        end else begin
          rec_t r;
          r = sb_q.pop_front();
          check($sformatf("sb_channel ch=%0d", c), c, r.ch);
          check($sformatf("table_out ch=%0d", c), m_tbl[c], r.tbl);
          check($sformatf("err_count ch=%0d", c), m_err[c], r.err);
          check($sformatf("first_err ch=%0d", c), m_first[c], r.first);
          check($sformatf("pass ch=%0d", c), m_pass[c], r.pass);
          check($sformatf("busy_cycles ch=%0d", c), bcnt[c], r.busy);
          check($sformatf("hold_min ch=%0d", c), hmin[c], r.hold);
          check($sformatf("hold_max ch=%0d", c), hmax[c], r.hold);
        end
      end
    end
  end

  initial begin
    int n;
    t_start = '0;
    t_rst   = '1;
    a_flip  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_vec",   m_vec[0],   0);
    check("rst_busy",  m_busy[0],  0);
    check("rst_done",  m_done[0],  0);
    check("rst_table", m_tbl[0],   0);
    check("rst_err",   m_err[0],   0);
    check("rst_first", m_first[0], 0);
    check("rst_pass",  m_pass[0],  0);
    check("rst_table_d", m_tbl[3], 0);
    t_rst = '0;
    @(negedge clk);

    // Correct block: (X&Y)|Z against 8'hEA
    expect_sweep(0, 64'hEA, 0, 0, 1, 16, 2);
    run_sweep(0);
    repeat (3) @(negedge clk);
    check("held_table", m_tbl[0],  64'hEA);
    check("held_pass",  m_pass[0], 1);
    check("held_done",  m_done[0], 0);
    check("held_busy",  m_busy[0], 0);

    // Faulty block: vectors 3 and 5 inverted
    a_flip = 8'h28;
    expect_sweep(0, 64'hC2, 2, 3, 0, 16, 2);
    run_sweep(0);
    a_flip = 8'h00;

    // Reset mid-sweep at vec=4, with start asserted alongside
    t_start[0] = 1'b1;
    @(negedge clk);
    t_start[0] = 1'b0;
    n = 0;
    while (m_vec[0] != 8'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_vec4", m_vec[0], 4);
    t_rst[0]   = 1'b1;
    t_start[0] = 1'b1;
    @(negedge clk);
    check("midrst_vec",   m_vec[0],   0);
    check("midrst_busy",  m_busy[0],  0);
    check("midrst_done",  m_done[0],  0);
    check("midrst_table", m_tbl[0],   0);
    check("midrst_err",   m_err[0],   0);
    check("midrst_first", m_first[0], 0);
    check("midrst_pass",  m_pass[0],  0);
    t_rst[0]   = 1'b0;
    t_start[0] = 1'b0;
    @(negedge clk);
    check("rst_start_ignored", m_busy[0], 0);
    expect_sweep(0, 64'hEA, 0, 0, 1, 16, 2);
    run_sweep(0);

    // start held high: back-to-back sweeps, start during RUN ignored
    expect_sweep(0, 64'hEA, 0, 0, 1, 16, 2);
    expect_sweep(0, 64'hEA, 0, 0, 1, 16, 2);
    t_start[0] = 1'b1;
    wait_done(0);
    @(negedge clk);
    check("b2b_busy", m_busy[0], 1);
    check("b2b_vec",  m_vec[0],  0);
    repeat (4) @(negedge clk);
    t_start[0] = 1'b0;
    wait_done(0);
    @(negedge clk);

    // SETTLE=1
    expect_sweep(1, 64'hEA, 0, 0, 1, 8, 1);
    run_sweep(1);

    // SETTLE=4 with a late change (captured) and an early transient (not captured)
    expect_sweep(2, 64'hEE, 1, 2, 0, 32, 4);
    run_sweep(2);

    // N_IN=4, N_OUT=2, f={^vec, vec[3]}
    expect_sweep(3, 64'h7DD78228, 0, 0, 1, 32, 2);
    run_sweep(3);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
